// File: rtl/add_seq_ctrl.sv
// Wide add/subtract sequencer: streams WORDS bytes, LSB first, through one
// external 8-bit ripple-carry adder and assembles the W-bit result.
module add_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 ovf,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    accept_s;
  logic                    last_s;
  logic [WORDS-1:0][7:0]   a_reg_r;
  logic [WORDS-1:0][7:0]   b_reg_r;
  logic [WORDS-1:0][7:0]   result_r;
  logic                    carry_r;
  logic [IDXW-1:0]         idx_r;
  logic                    cout_r;
  logic                    ovf_r;
  logic                    busy_s;
  logic                    done_s;
  logic [7:0]              add_a_s;
  logic [7:0]              add_b_s;
  logic                    add_cin_s;

  // Signed overflow: operands agree in sign but the top byte of the sum does not.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; DONE accepts a new start just like IDLE
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = (idx_r == LAST_IDX);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode; the adder inputs are quiet outside RUN
  always_comb begin
    busy_s    = 1'b0;
    done_s    = 1'b0;
    add_a_s   = 8'h00;
    add_b_s   = 8'h00;
    add_cin_s = 1'b0;
    case (state_r)
      RUN: begin
        busy_s    = 1'b1;
        add_a_s   = a_reg_r[idx_r];
        add_b_s   = b_reg_r[idx_r];
        add_cin_s = carry_r;
      end
      DONE: begin
        done_s = 1'b1;
      end
      IDLE: begin
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Operand latch, carry chain and byte-wise result assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg_r  <= '0;
      b_reg_r  <= '0;
      result_r <= '0;
      carry_r  <= 1'b0;
      idx_r    <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is a + ~b + 1: invert B once and seed the carry.
      a_reg_r <= a;
      b_reg_r <= sub ? ~b : b;
      carry_r <= sub;
      idx_r   <= '0;
    end else if (state_r == RUN) begin
      result_r[idx_r] <= add_sum;
      carry_r         <= add_cout;
      if (last_s) begin
        idx_r  <= '0;
        cout_r <= add_cout;
        ovf_r  <= ovf_calc(a_reg_r[WORDS-1][7], b_reg_r[WORDS-1][7], add_sum[7]);
      end else begin
        idx_r <= idx_r + IDXW'(1);
      end
    end
  end

  assign busy    = busy_s;
  assign done    = done_s;
  assign result  = result_r;
  assign cout    = cout_r;
  assign ovf     = ovf_r;
  assign add_a   = add_a_s;
  assign add_b   = add_b_s;
  assign add_cin = add_cin_s;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (WORDS=4) with a behavioural RCA8 attached.
module tb_add_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;

  int checks;
  int failures;

  add_seq_ctrl #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // External 8-bit adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_result;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation; optionally pulses start with junk operands mid-RUN.
  task automatic run_op(input string name, input vec_t v, input bit interfere);
    int done_k;
    int busy_cnt;
    int done_cnt;
    done_k   = 0;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
        chk({name, ".result"}, {32'h0, result}, {32'h0, v.exp_result});
        chk({name, ".cout"}, {63'h0, cout}, {63'h0, v.exp_cout});
        chk({name, ".ovf"}, {63'h0, ovf}, {63'h0, v.exp_ovf});
      end
      if (interfere && k == 2) begin
        start = 1'b1; a = 32'hDEADBEEF; b = 32'h0BADF00D; sub = ~v.sub;
      end
      if (interfere && k == 3) start = 1'b0;
    end
    chk({name, ".done_latency"}, 64'(done_k), 64'd5);
    chk({name, ".busy_cycles"}, 64'(busy_cnt), 64'd4);
    chk({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
    chk({name, ".result_held"}, {32'h0, result}, {32'h0, v.exp_result});
  endtask

  initial begin
    int d1;
    int d2;
    int nd;
    checks   = 0;
    failures = 0;
    start = 1'b0; sub = 1'b0; a = 32'h0; b = 32'h0;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h00000010, 32'h00000010, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.busy", {63'h0, busy}, 64'd0);
    chk("reset.done", {63'h0, done}, 64'd0);
    chk("reset.result", {32'h0, result}, 64'd0);
    chk("reset.cout_ovf", {62'h0, cout, ovf}, 64'd0);
    chk("reset.adder_in", {47'h0, add_a, add_b, add_cin}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // start pulsed mid-RUN with other operands must be ignored
    run_op("ignore_start", vecs[7], 1'b1);

    // Back-to-back: start held through the DONE cycle
    d1 = 0; d2 = 0; nd = 0;
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) begin
          d1 = k;
          chk("b2b.result1", {32'h0, result}, 64'h33333333);
        end else begin
          d2 = k;
          chk("b2b.result2", {32'h0, result}, 64'h000000FF);
          chk("b2b.cout2", {63'h0, cout}, 64'd1);
        end
      end
      if (k == 4) begin
        a = 32'h00000100; b = 32'h00000001; sub = 1'b1; start = 1'b1;
      end
      if (k == 6) start = 1'b0;
    end
    chk("b2b.done1_at", 64'(d1), 64'd5);
    chk("b2b.done2_at", 64'(d2), 64'd10);

    // Reset in the second RUN cycle aborts the op
    nd = 0;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("abort.busy_before", {63'h0, busy}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", {63'h0, busy}, 64'd0);
    chk("abort.result", {32'h0, result}, 64'd0);
    chk("abort.adder_in", {47'h0, add_a, add_b, add_cin}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort.no_activity", 64'(nd), 64'd0);
    run_op("after_abort", vecs[4], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
